// File: rtl/ad5328_pkg.sv
// ad5328_pkg: shared widths, code/channel types and controller states
package ad5328_pkg;
  localparam int NUM_CH = 32;
  localparam int DAC_W = 12;
  typedef logic [DAC_W-1:0] code_t;
  typedef logic [$clog2(NUM_CH)-1:0] ch_t;
  typedef enum logic [2:0] {IDLE, STEP, START, WAIT_LDAC, DONE} state_t;
endpackage

// File: rtl/ad5328_ctrl_if.sv
// ad5328_ctrl_if: controller-to-driver bus (codes, start pulse, ldac completion)
interface ad5328_ctrl_if;
  ad5328_pkg::code_t [ad5328_pkg::NUM_CH-1:0] dac_data;
  logic dac_update;
  logic dac_ldac_n;
  modport master(output dac_data, dac_update, input dac_ldac_n);
  modport slave(input dac_data, dac_update, output dac_ldac_n);
endinterface

// File: rtl/ad5328_ramp_step.sv
// ad5328_ramp_step: next code moving current toward target by at most step
module ad5328_ramp_step
  import ad5328_pkg::*;
(
  input  code_t cur_i,
  input  code_t tgt_i,
  input  code_t step_i,
  output code_t nxt_o
);
  logic  up;
  code_t diff;
  assign up = tgt_i > cur_i;
  assign diff = up ? tgt_i - cur_i : cur_i - tgt_i;
  // the far-branch sums cannot wrap because diff > step there
  assign nxt_o = (step_i == '0 || diff <= step_i) ? tgt_i : up ? cur_i + step_i : cur_i - step_i;
endmodule

// File: rtl/ad5328_ctrl.sv
// ad5328_ctrl: 32-channel DAC code uploader with refresh, timeout and optional ramp (AD5328_CTRL_RAMP_EN)
module ad5328_ctrl
  import ad5328_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int REFRESH_W = 16
) (
  input  logic                 dtc_clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  ch_t                  wr_addr,
  input  code_t                wr_data,
  input  ch_t                  rd_addr,
  output code_t                rd_data,
  input  logic                 update_req,
  input  logic [REFRESH_W-1:0] refresh_period,
  input  code_t                ramp_step,
  input  logic                 err_clr,
  ad5328_ctrl_if.master        dac,
  output logic                 busy,
  output logic                 done,
  output logic                 ramp_active,
  output logic                 err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t                 state_q, state_d;
  ch_t                    ch_q, ch_d;
  logic                   req_q, req_d;
  logic [REFRESH_W-1:0]   rcnt_q, rcnt_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   err_q, err_d;
  code_t [NUM_CH-1:0]     tgt_q, tgt_d, cur_q, cur_d;
  code_t                  rd_data_q, nxt_code;
  logic                   expire, go;
`ifdef AD5328_CTRL_RAMP_EN
  ad5328_ramp_step u_ramp (
    .cur_i (cur_q[ch_q]),
    .tgt_i (tgt_q[ch_q]),
    .step_i(ramp_step),
    .nxt_o (nxt_code)
  );
  assign ramp_active = cur_q != tgt_q;
`else
  logic unused_ramp_step;
  assign unused_ramp_step = ^ramp_step;
  assign nxt_code = tgt_q[ch_q];
  assign ramp_active = 1'b0;
`endif
  assign expire = (refresh_period != '0) && (rcnt_q >= refresh_period - REFRESH_W'(1));
  assign go = req_q | update_req | expire | ramp_active;
  assign dac.dac_data = cur_q;
  assign dac.dac_update = state_q == START;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
  assign rd_data = rd_data_q;
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    req_d = req_q | update_req;
    rcnt_d = '0;
    tmo_d = '0;
    err_d = err_clr ? 1'b0 : err_q;
    tgt_d = tgt_q;
    cur_d = cur_q;
    if (wr_en) tgt_d[wr_addr] = wr_data;
    case (state_q)
      IDLE: if (go) begin
        state_d = STEP;
        req_d = 1'b0;
      end else rcnt_d = rcnt_q + REFRESH_W'(1);
      STEP: begin
        cur_d[ch_q] = nxt_code;
        ch_d = ch_q + ch_t'(1);
        state_d = ch_q == '1 ? START : STEP;
      end
      START: state_d = WAIT_LDAC;
      WAIT_LDAC: if (!dac.dac_ldac_n) state_d = DONE;
      else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        err_d = 1'b1;
      end else tmo_d = tmo_q + TW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      req_q <= 1'b0;
      rcnt_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
      tgt_q <= '0;
      cur_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      req_q <= req_d;
      rcnt_q <= rcnt_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      rd_data_q <= cur_q[rd_addr];
    end
  end
endmodule
